// File: rtl/wb_pwm_slave_pkg.sv
// Shared definitions for the Wishbone PWM slave: register offsets, bit
// positions, ack FSM states and the byte-lane merge helper.
package wb_pwm_slave_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  // Register offsets within the slave's 256-byte window
  localparam logic [7:0] ADR_CTRL   = 8'h00;
  localparam logic [7:0] ADR_PERIOD = 8'h04;
  localparam logic [7:0] ADR_DUTY   = 8'h08;
  localparam logic [7:0] ADR_COUNT  = 8'h0C;
  localparam logic [7:0] ADR_STATUS = 8'h10;

  // Bit positions inside CTRL and STATUS
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STATUS_WRAP_BIT = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ack_state_e;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_PERIOD,
    REG_DUTY,
    REG_COUNT,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  // Word decode; the two low address bits are ignored
  function automatic reg_sel_e decode_adr(input logic [7:0] adr);
    reg_sel_e r;
    case (adr[7:2])
      ADR_CTRL[7:2]:   r = REG_CTRL;
      ADR_PERIOD[7:2]: r = REG_PERIOD;
      ADR_DUTY[7:2]:   r = REG_DUTY;
      ADR_COUNT[7:2]:  r = REG_COUNT;
      ADR_STATUS[7:2]: r = REG_STATUS;
      default:         r = REG_NONE;
    endcase
    return r;
  endfunction

  // Replace the byte lanes of old_v selected by sel with those of new_v
  function automatic logic [DATA_W-1:0] apply_sel(input logic [DATA_W-1:0] old_v,
                                                  input logic [DATA_W-1:0] new_v,
                                                  input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < SEL_W; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_pwm_slave_pwm_sayac.sv
// PWM core: free-running counter, active PERIOD/DUTY with shadow load,
// wrap pulse and the registered PWM output.
module pwm_sayac
  import wb_pwm_slave_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PERIOD = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [DATA_W-1:0] period_sh_i,  // shadow value as it will be after this edge
  input  logic [DATA_W-1:0] duty_sh_i,    // shadow value as it will be after this edge
  input  logic              cnt_wr_i,
  input  logic [DATA_W-1:0] cnt_wdata_i,
  output logic [DATA_W-1:0] count_o,
  output logic              wrap_o,
  output logic              pwm_o
);

  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] period_q;
  logic [DATA_W-1:0] duty_q;
  logic              pwm_q;
  logic              run;
  logic              at_end;
  logic              load_act;

  // Run/wrap decode; the >= compare also recovers a count loaded past the period
  always_comb begin
    run      = en_i & (period_q != '0);
    at_end   = (count_q >= period_q - DATA_W'(1));
    wrap_o   = run & at_end;
    // A stopped or zero-period channel has no period in progress, so the
    // shadows follow straight through; otherwise they land only on a wrap.
    load_act = ~run | wrap_o;
  end

  // Counter: zero period pins it at 0, a bus load beats a wrap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                count_q <= '0;
    else if (period_q == '0)    count_q <= '0;
    else if (cnt_wr_i)          count_q <= cnt_wdata_i;
    else if (wrap_o)            count_q <= '0;
    else if (run)               count_q <= count_q + DATA_W'(1);
  end

  // Active PERIOD/DUTY double buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period_q <= RESET_PERIOD;
      duty_q   <= '0;
    end else if (load_act) begin
      period_q <= period_sh_i;
      duty_q   <= duty_sh_i;
    end
  end

  // Registered PWM output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pwm_q <= 1'b0;
    else         pwm_q <= run & (count_q < duty_q);
  end

  assign count_o = count_q;
  assign pwm_o   = pwm_q;

endmodule

// File: rtl/wb_pwm_slave.sv
// Wishbone responder for the single-channel PWM: ack FSM, register file with
// byte-masked writes, registered read mux and the wrap interrupt.
module wb_pwm_slave
  import wb_pwm_slave_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PERIOD = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [7:0]        adr_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] dat_o,
  output logic              pwm_o,
  output logic              irq_o
);

  ack_state_e        state_q, state_d;
  reg_sel_e          rsel;
  logic              commit;
  logic              wr;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] period_q, period_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic              wrap_q;
  logic              w1c;
  logic              irq_q;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] count;
  logic              wrap_pulse;
  logic              cnt_wr;
  logic [DATA_W-1:0] cnt_wdata;

  assign rsel   = decode_adr(adr_i);
  assign commit = (state_q == ST_IDLE) & cyc_i & stb_i;
  assign wr     = commit & we_i;

  // Ack FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Ack FSM next state; ACK always falls back to IDLE so a held strobe is not re-acked
  always_comb begin
    state_d = state_q;
    ack_o   = 1'b0;
    case (state_q)
      ST_IDLE: if (cyc_i & stb_i) state_d = ST_ACK;
      ST_ACK: begin
        ack_o   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write decode and byte merge; shadow next values also feed the PWM core
  always_comb begin
    ctrl_d    = ctrl_q;
    period_d  = period_q;
    duty_d    = duty_q;
    cnt_wr    = 1'b0;
    cnt_wdata = apply_sel(count, dat_i, sel_i);
    w1c       = 1'b0;
    if (wr) begin
      case (rsel)
        REG_CTRL:   if (sel_i[0]) ctrl_d = dat_i[1:0];
        REG_PERIOD: period_d = apply_sel(period_q, dat_i, sel_i);
        REG_DUTY:   duty_d   = apply_sel(duty_q, dat_i, sel_i);
        REG_COUNT:  cnt_wr   = 1'b1;
        REG_STATUS: w1c      = sel_i[0] & dat_i[STATUS_WRAP_BIT];
        default:    ;
      endcase
    end
  end

  // Read mux over the pre-commit register state
  always_comb begin
    rdata = '0;
    case (rsel)
      REG_CTRL:   rdata = {{(DATA_W-2){1'b0}}, ctrl_q};
      REG_PERIOD: rdata = period_q;
      REG_DUTY:   rdata = duty_q;
      REG_COUNT:  rdata = count;
      REG_STATUS: rdata = {{(DATA_W-1){1'b0}}, wrap_q};
      default:    rdata = '0;
    endcase
  end

  // Register file commit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q   <= '0;
      period_q <= RESET_PERIOD;
      duty_q   <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      duty_q   <= duty_d;
    end
  end

  // WRAP flag: a wrap on the same edge as the clear keeps it set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wrap_q <= 1'b0;
    else         wrap_q <= wrap_pulse | (wrap_q & ~w1c);
  end

  // Read data register, non-zero only during the ack cycle of a read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               rdata_q <= '0;
    else if (commit & ~we_i)   rdata_q <= rdata;
    else                       rdata_q <= '0;
  end

  // Registered level interrupt
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= wrap_q & ctrl_q[CTRL_IRQ_EN_BIT];
  end

  assign dat_o = rdata_q;
  assign irq_o = irq_q;

  pwm_sayac #(
    .RESET_PERIOD (RESET_PERIOD)
  ) u_pwm_sayac (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (ctrl_q[CTRL_EN_BIT]),
    .period_sh_i (period_d),
    .duty_sh_i   (duty_d),
    .cnt_wr_i    (cnt_wr),
    .cnt_wdata_i (cnt_wdata),
    .count_o     (count),
    .wrap_o      (wrap_pulse),
    .pwm_o       (pwm_o)
  );

endmodule
